// File: rtl/mux_scan_n.sv
//==============================================================================
// Module      : mux_scan_n
// Description : N-channel, W-bit registered mux with manual select and a
//               round-robin scan mode with programmable dwell and wrap pulse.
//               Optional macro MUX_SCAN_MASK_EN lets ch_mask gate the scan.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_scan_n #(
    parameter  int N     = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   din,
    input  logic [SW-1:0]    sel,
    input  logic             sel_load,
    input  logic             scan_en,
    input  logic [N-1:0]     ch_mask,
    output logic [W-1:0]     y,
    output logic [SW-1:0]    ch,
    output logic             wrap
);

    localparam int            CW         = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(DWELL - 1);
    localparam logic [SW:0]   c_n        = (SW + 1)'(N);

    logic [SW-1:0] r_ch;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_y;
    logic          r_wrap;

    logic [N-1:0]  w_en;
    logic [W-1:0]  w_y;
    logic          w_hi_found;
    logic [SW-1:0] w_hi_ch;
    logic          w_any;
    logic [SW-1:0] w_lo_ch;
    logic [SW-1:0] w_next;
    logic          w_sel_ok;

`ifdef MUX_SCAN_MASK_EN
    assign w_en = ch_mask;
`else
    logic w_unused_mask;
    assign w_en          = '1;
    assign w_unused_mask = ^ch_mask;
`endif

    always_comb begin
        w_y = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ch == SW'(i)) begin
                w_y = din[i*W +: W];
            end
        end
    end

    // Descending scan: the last hit is the lowest index. Lowest enabled above
    // the current channel wins; otherwise fall back to lowest overall (a wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_ch    = '0;
        w_any      = 1'b0;
        w_lo_ch    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_en[i]) begin
                if (SW'(i) > r_ch) begin
                    w_hi_found = 1'b1;
                    w_hi_ch    = SW'(i);
                end
                w_any   = 1'b1;
                w_lo_ch = SW'(i);
            end
        end
        w_next = w_hi_found ? w_hi_ch : w_lo_ch;
    end

    assign w_sel_ok = ({1'b0, sel} < c_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_y    <= w_y;
            r_wrap <= 1'b0;
            if (scan_en) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_ch   <= w_next;
                        r_wrap <= ~w_hi_found;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
                if (sel_load && w_sel_ok) begin
                    r_ch <= sel;
                end
            end
        end
    end

    assign y    = r_y;
    assign ch   = r_ch;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_n.sv
//==============================================================================
// Module      : tb_mux_scan_n
// Description : Directed self-checking bench for mux_scan_n (two instances:
//               8x1b dwell 4, and 6x4b dwell 1). Honours MUX_SCAN_MASK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_scan_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] din      = '0;
    logic [2:0] sel      = '0;
    logic       sel_load = 1'b0;
    logic       scan_en  = 1'b0;
    logic [7:0] ch_mask  = 8'hff;
    logic       y;
    logic [2:0] ch;
    logic       wrap;

    logic [23:0] din2      = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    logic [2:0]  sel2      = '0;
    logic        sel_load2 = 1'b0;
    logic        scan_en2  = 1'b0;
    logic [5:0]  ch_mask2  = 6'h3f;
    logic [3:0]  y2;
    logic [2:0]  ch2;
    logic        wrap2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.N(8), .W(1), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .sel_load(sel_load),
        .scan_en(scan_en), .ch_mask(ch_mask), .y(y), .ch(ch), .wrap(wrap)
    );

    mux_scan_n #(.N(6), .W(4), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .sel(sel2), .sel_load(sel_load2),
        .scan_en(scan_en2), .ch_mask(ch_mask2), .y(y2), .ch(ch2), .wrap(wrap2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        din = 8'hff;
        do_reset();
        n_checks++;
        if (ch !== 3'd0 || y !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ch=%0d y=%b wrap=%b, required ch=0 y=0 wrap=0", ch, y, wrap);
        end
    endtask

    task automatic test_manual();
        logic [7:0] exp_y;
        exp_y   = 8'b10101111;
        din     = 8'b10101111;
        scan_en = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel      = 3'(s);
            sel_load = 1'b1;
            tick();
            sel_load = 1'b0;
            n_checks++;
            if (ch !== 3'(s)) begin
                n_fail++;
                $display("FAIL manual_ch[%0d]: ch=%0d, required %0d", s, ch, s);
            end
            if (s > 0) begin
                n_checks++;
                if (y !== exp_y[s-1]) begin
                    n_fail++;
                    $display("FAIL manual_latency[%0d]: y=%b, required old %b", s, y, exp_y[s-1]);
                end
            end
            tick();
            n_checks++;
            if (y !== exp_y[s]) begin
                n_fail++;
                $display("FAIL manual_y[%0d]: y=%b, required %b", s, y, exp_y[s]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_scan_full();
        int wraps;
        wraps   = 0;
        ch_mask = 8'hff;
        scan_en = 1'b1;
        do_reset();
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (wrap === 1'b1) wraps++;
            n_checks++;
            if (ch !== 3'((t / 4) % 8) || wrap !== ((t % 32) == 0)) begin
                n_fail++;
                $display("FAIL scan_full t=%0d: ch=%0d wrap=%b, required ch=%0d wrap=%b",
                         t, ch, wrap, (t / 4) % 8, (t % 32) == 0);
            end
        end
        n_checks++;
        if (wraps != 2) begin
            n_fail++;
            $display("FAIL scan_wrap_count: got %0d wraps, required 2", wraps);
        end
        scan_en = 1'b0;
    endtask

    task automatic test_scan_masked();
        int seq [3];
        int e_ch;
        logic e_wrap;
        seq     = '{0, 2, 7};
        ch_mask = 8'b1000_0101;
        scan_en = 1'b1;
        do_reset();
        for (int t = 1; t <= 28; t++) begin
            tick();
`ifdef MUX_SCAN_MASK_EN
            e_ch   = seq[(t / 4) % 3];
            e_wrap = (t % 12) == 0;
`else
            e_ch   = (t / 4) % 8;
            e_wrap = (t % 32) == 0;
`endif
            n_checks++;
            if (ch !== 3'(e_ch) || wrap !== e_wrap) begin
                n_fail++;
                $display("FAIL scan_masked t=%0d: ch=%0d wrap=%b, required ch=%0d wrap=%b",
                         t, ch, wrap, e_ch, e_wrap);
            end
        end
        // t=28 leaves cnt at 0; ch shown is seq[7%3]=2 (masked) or 7 (unmasked)
        ch_mask = 8'h00;
        for (int t = 29; t <= 48; t++) begin
            tick();
`ifdef MUX_SCAN_MASK_EN
            e_ch   = 2;
            e_wrap = 1'b0;
`else
            e_ch   = (t / 4) % 8;
            e_wrap = (t % 32) == 0;
`endif
            n_checks++;
            if (ch !== 3'(e_ch) || wrap !== e_wrap) begin
                n_fail++;
                $display("FAIL scan_nomask t=%0d: ch=%0d wrap=%b, required ch=%0d wrap=%b",
                         t, ch, wrap, e_ch, e_wrap);
            end
        end
        ch_mask = 8'hff;
        scan_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        din     = 8'hff;
        ch_mask = 8'hff;
        scan_en = 1'b1;
        do_reset();
        for (int t = 1; t <= 22; t++) tick();
        n_checks++;
        if (ch !== 3'd5 || y !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_pre: ch=%0d y=%b, required ch=5 y=1", ch, y);
        end
        do_reset();
        n_checks++;
        if (ch !== 3'd0 || y !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_reset: ch=%0d y=%b wrap=%b, required 0 0 0", ch, y, wrap);
        end
        for (int t = 1; t <= 4; t++) begin
            tick();
            n_checks++;
            if (ch !== ((t == 4) ? 3'd1 : 3'd0)) begin
                n_fail++;
                $display("FAIL midscan_dwell t=%0d: ch=%0d, required %0d", t, ch, (t == 4) ? 1 : 0);
            end
        end
        scan_en = 1'b0;
    endtask

    task automatic test_priority();
        din     = 8'b0100_0000;
        ch_mask = 8'hff;
        scan_en = 1'b1;
        do_reset();
        for (int t = 1; t <= 6; t++) begin
            sel      = 3'd6;
            sel_load = (t <= 2);
            tick();
            n_checks++;
            if (ch !== 3'((t / 4) % 8)) begin
                n_fail++;
                $display("FAIL priority_scan t=%0d: ch=%0d, required %0d", t, ch, (t / 4) % 8);
            end
        end
        sel_load = 1'b0;
        scan_en  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (ch !== 3'd1 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL priority_freeze k=%0d: ch=%0d wrap=%b, required ch=1 wrap=0", k, ch, wrap);
            end
        end
        sel      = 3'd6;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        n_checks++;
        if (ch !== 3'd6) begin
            n_fail++;
            $display("FAIL priority_load: ch=%0d, required 6", ch);
        end
        tick();
        n_checks++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_y: y=%b, required 1", y);
        end
    endtask

    task automatic test_invalid_sel();
        scan_en2  = 1'b0;
        sel2      = 3'd3;
        sel_load2 = 1'b1;
        tick();
        sel_load2 = 1'b0;
        tick();
        n_checks++;
        if (ch2 !== 3'd3 || y2 !== 4'hD) begin
            n_fail++;
            $display("FAIL sel_valid: ch=%0d y=%h, required ch=3 y=d", ch2, y2);
        end
        for (int v = 6; v <= 7; v++) begin
            sel2      = 3'(v);
            sel_load2 = 1'b1;
            tick();
            sel_load2 = 1'b0;
            tick();
            n_checks++;
            if (ch2 !== 3'd3 || y2 !== 4'hD) begin
                n_fail++;
                $display("FAIL sel_invalid[%0d]: ch=%0d y=%h, required ch=3 y=d", v, ch2, y2);
            end
        end
    endtask

    task automatic test_dwell_one();
        scan_en2 = 1'b1;
        ch_mask2 = 6'h3f;
        do_reset();
        for (int t = 1; t <= 13; t++) begin
            tick();
            n_checks++;
            if (ch2 !== 3'(t % 6) || wrap2 !== ((t % 6) == 0)) begin
                n_fail++;
                $display("FAIL dwell1 t=%0d: ch=%0d wrap=%b, required ch=%0d wrap=%b",
                         t, ch2, wrap2, t % 6, (t % 6) == 0);
            end
        end
        scan_en2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_manual();
        test_scan_full();
        test_scan_masked();
        test_reset_mid_scan();
        test_priority();
        test_invalid_sel();
        test_dwell_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised N-channel, W-bit registered multiplexer with manual select and an automatic round-robin scan mode. Each channel is held for a programmable dwell time, and a wrap pulse marks the end of each scan pass. It generalises the fixed 8:1 single-bit mux into a clocked channel sequencer. It sits between a bank of parallel sources and a single serial consumer, for example a shared display, UART or probe pin.

## Interface
Parameters:
- `N`, 8, number of channels; N ≥ 2
- `W`, 1, data width per channel; W ≥ 1
- `DWELL`, 4, cycles each channel is held in scan mode; DWELL ≥ 1
- `SW`, derived, $clog2(N), select/index width (localparam)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `din`  in  N*W  channel data; channel i = din[i*W +: W]
- `sel`  in  SW  manual channel select
- `sel_load`  in  1  latch `sel` into current channel (manual mode only)
- `scan_en`  in  1  1 = auto-scan mode, 0 = manual mode
- `ch_mask`  in  N  channel enable mask for scanning; bit i = 1 enables channel i (see Configuration)
- `y`  out  W  registered output data
- `ch`  out  SW  current channel index (registered)
- `wrap`  out  1  one-cycle pulse on scan wrap-around

## Operation
- State: channel register `ch`, dwell counter `cnt` (width $clog2(DWELL)+1), output register `y`, `wrap` flag.
- Control priority, highest first: `rst` > `scan_en` > `sel_load`.
- Reset values: `ch`=0, `cnt`=0, `y`=0, `wrap`=0.
- Data path: every cycle, `y` <= din[ch*W +: W], using the `ch` value before the edge.

Manual mode (`scan_en`=0):
- `cnt` is held at 0 and `wrap` is 0.
- `sel_load`=1 with `sel` < N: `ch` <= `sel`.
- `sel_load`=1 with `sel` ≥ N: ignored; `ch` holds.
- `ch_mask` has no effect; a masked channel may be selected manually.

Scan mode (`scan_en`=1):
- `sel_load` is ignored.
- Each cycle, `cnt` increments.
- When `cnt`==DWELL-1: `cnt` <= 0, and `ch` <= next channel.
- Next channel: the first enabled index searching circularly upward from ch+1.
- `wrap` is 1 in the cycle `ch` updates if next ≤ current, i.e. a circular pass completed. N-1→0 is a wrap.
- Only the current channel enabled: `ch` holds and `wrap` pulses once per DWELL cycles.
- No channel enabled: `ch` holds, `cnt` keeps running, `wrap` stays 0.

Mode changes:
- Entering scan: starts from the current `ch` with `cnt`=0, so the current channel gets a full DWELL period.
- Leaving scan: `ch` holds and `cnt` is cleared on that edge.

Reset mid-scan: all state returns to reset values on the next edge. Scanning resumes from channel 0 with a full dwell period if `scan_en` is still 1.

## Timing
- `din` → `y` latency: 1 cycle.
- `sel_load` at edge k → `ch` new value after edge k → `y` shows the new channel after edge k+1. Select-to-data latency is 2 cycles.
- Scan: `ch` is stable for exactly DWELL cycles per enabled channel.
- `wrap` is asserted in the same cycle `ch` shows the post-wrap index, for exactly 1 cycle.
- Full-pass period: DWELL × (number of enabled channels) cycles.
- DWELL=1: `ch` advances every cycle.

## Configuration
- Macro: `MUX_SCAN_MASK_EN`.
- Defined: `ch_mask` gates the scan sequence as described above.
- Undefined: the `ch_mask` port is still present but ignored, and all N channels are treated as enabled. `ch` then steps 0,1,…,N-1,0 with `wrap` on every N-1→0 transition.

## Test plan
1. Manual select, N=8, W=1, din=8'b10101111: load `sel`=0..7, one per 4 cycles → `y` = 1,1,1,1,0,1,0,1, each value appearing 2 cycles after its `sel_load`.
2. Scan, DWELL=4, mask all ones: `ch` = 0..7 with 4 cycles each; `wrap` pulses once when `ch` goes 7→0; period is 32 cycles.
3. Invalid select, N=6: `ch`=3, then `sel_load` with `sel`=7 → `ch` stays 3 and `y` stays din channel 3.
4. Masked scan (macro defined), N=8, ch_mask=8'b1000_0101 → `ch` sequence 0,2,7,0,…; `wrap` only on 7→0. Then ch_mask=0 → `ch` holds and `wrap` stays 0. Repeat with the macro undefined → all 8 channels are scanned.
5. Reset mid-scan at `ch`=5, `cnt`=2: `rst` for 1 cycle → next cycle `ch`=0, `y`=0, `wrap`=0. Channel 0 is then held for a full DWELL cycles.
6. Priority: `scan_en`=1 and `sel_load`=1 with `sel`=6 in the same cycle → `sel` is ignored and scanning continues. Drop `scan_en` mid-dwell → `ch` freezes. Next `sel_load` with `sel`=6 → `ch`=6.
